// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and FIPS-197 reference vectors for the
// iterative AES-128 round sequencer and its benches.
package aes_pkg;

  localparam int unsigned AES_NR      = 10;
  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_SEL_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } seq_state_e;

  // FIPS-197 Appendix B worked example
  localparam logic [AES_BLOCK_W-1:0] FIPS_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [AES_BLOCK_W-1:0] FIPS_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [AES_BLOCK_W-1:0] FIPS_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  // FIPS-197 Appendix C.1 AES-128 example
  localparam logic [AES_BLOCK_W-1:0] FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLOCK_W-1:0] FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [AES_BLOCK_W-1:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: owns the state register, steps the
// external round function one round per clock and applies AddRoundKey inline.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR      = AES_NR,
  parameter int unsigned BLOCK_W = AES_BLOCK_W,
  parameter int unsigned SEL_W   = AES_SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic [SEL_W-1:0]   rk_sel,
  input  logic [BLOCK_W-1:0] rk_data,
  output logic [BLOCK_W-1:0] rnd_state,
  output logic               rnd_last,
  input  logic [BLOCK_W-1:0] rnd_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  seq_state_e         r_fsm;
  seq_state_e         w_fsm_nxt;
  logic [SEL_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   w_cnt_nxt;
  logic [BLOCK_W-1:0] r_blk;
  logic [BLOCK_W-1:0] w_blk_nxt;
  logic               w_final;

  assign w_final   = (r_cnt == SEL_W'(NR));
  assign rnd_state = r_blk;
  assign out_data  = r_blk;

  // State, round counter and block register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
      r_cnt <= '0;
      r_blk <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_cnt <= w_cnt_nxt;
      r_blk <= w_blk_nxt;
    end
  end

  // Next-state and output decode; outputs depend only on r_fsm and r_cnt
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_cnt_nxt = r_cnt;
    w_blk_nxt = r_blk;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_sel    = '0;
    rnd_last  = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_blk_nxt = in_data ^ rk_data;
          w_cnt_nxt = SEL_W'(1);
          w_fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        busy      = 1'b1;
        rk_sel    = r_cnt;
        rnd_last  = w_final;
        w_blk_nxt = rnd_result ^ rk_data;
        if (w_final) begin
          w_cnt_nxt = '0;
          w_fsm_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + SEL_W'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: models the external round function and key
// mux, and checks ciphertexts against a whole-block AES-128 reference.
module tb_aes_round_sequencer;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_sel;
  logic [127:0] rk_data;
  logic [127:0] rnd_state;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [10:0][127:0] ks_cur = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_sel    (rk_sel),
    .rk_data   (rk_data),
    .rnd_state (rnd_state),
    .rnd_last  (rnd_last),
    .rnd_result(rnd_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- AES-128 arithmetic (FIPS-197) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p, e;
    r = 8'h01;
    p = x;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ ((r << 1) | (r >> 7)) ^ ((r << 2) | (r >> 6))
             ^ ((r << 3) | (r >> 5)) ^ ((r << 4) | (r >> 4)) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                              ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  function automatic logic [10:0][127:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [10:0][127:0] ks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // Whole-block reference encryption
  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [10:0][127:0] ks;
    logic [127:0] s;
    ks = expand(key);
    s  = pt ^ ks[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ ks[r];
    return sub_shift(s) ^ ks[10];
  endfunction

  // External datapath seen by the sequencer
  assign rk_data    = (rk_sel <= 4'd10) ? ks_cur[rk_sel] : '0;
  assign rnd_result = rnd_last ? sub_shift(rnd_state) : mix(sub_shift(rnd_state));

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  128'(in_ready),  128'd1);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, ".busy"},      128'(busy),      128'd0);
    chk({tag, ".rk_sel"},    128'(rk_sel),    128'd0);
    chk({tag, ".rnd_last"},  128'(rnd_last),  128'd0);
  endtask

  // One full block: accept, round sequencing, optional backpressure, drain
  task automatic do_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input int bp, input bit keep_valid,
                          input logic [127:0] next_pt, output int acc_cyc);
    ks_cur = expand(key);
    for (int t = 0; t < 40 && !in_ready; t++) @(negedge clk);
    chk({tag, ".wait_in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, ".idle_rk_sel"},   128'(rk_sel),   128'd0);
    in_valid  = 1'b1;
    in_data   = pt;
    out_ready = (bp == 0);
    acc_cyc   = cyc;
    @(negedge clk);
    if (keep_valid) begin
      in_data = next_pt;
    end else begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("%s.rk_sel[%0d]", tag, k),    128'(rk_sel),    128'(k));
      chk($sformatf("%s.rnd_last[%0d]", tag, k),  128'(rnd_last),  128'(k == 10));
      chk($sformatf("%s.in_ready[%0d]", tag, k),  128'(in_ready),  128'd0);
      chk($sformatf("%s.out_valid[%0d]", tag, k), 128'(out_valid), 128'd0);
      chk($sformatf("%s.busy[%0d]", tag, k),      128'(busy),      128'd1);
      @(negedge clk);
    end
    chk({tag, ".out_valid"},     128'(out_valid), 128'd1);
    chk({tag, ".out_data"},      out_data,        exp);
    chk({tag, ".done_rk_sel"},   128'(rk_sel),    128'd0);
    chk({tag, ".done_rnd_last"}, 128'(rnd_last),  128'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk($sformatf("%s.bp_valid[%0d]", tag, i), 128'(out_valid), 128'd1);
      chk($sformatf("%s.bp_data[%0d]", tag, i),  out_data,        exp);
      chk($sformatf("%s.bp_ready[%0d]", tag, i), 128'(in_ready),  128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_idle({tag, ".after"});
    out_ready = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [127:0] key, pt, pt2;
    int acc1, acc2, bp;
    bit seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset.out_data",  out_data,  128'd0);
    chk("reset.rnd_state", rnd_state, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_block("c1", FIPS_C1_KEY, FIPS_C1_PT, FIPS_C1_CT, 0, 1'b0, '0, acc1);
    do_block("c1_bp", FIPS_C1_KEY, FIPS_C1_PT, FIPS_C1_CT, 5, 1'b0, '0, acc1);

    // in_valid held with a different block while busy
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    do_block("busy1", FIPS_C1_KEY, FIPS_C1_PT, FIPS_C1_CT, 0, 1'b1, pt2, acc1);
    do_block("busy2", FIPS_C1_KEY, pt2, aes_encrypt(FIPS_C1_KEY, pt2), 0, 1'b0, '0, acc2);
    chk("busy.period", 128'(acc2 - acc1), 128'd12);

    // Reset in the middle of round 5
    ks_cur    = expand(FIPS_B_KEY);
    in_valid  = 1'b1;
    in_data   = FIPS_B_PT;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid.rk_sel", 128'(rk_sel), 128'd5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("mid_reset");
    chk("mid_reset.out_data", out_data, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen = seen | out_valid;
      @(negedge clk);
    end
    chk("mid_reset.no_output", 128'(seen), 128'd0);
    out_ready = 1'b0;

    do_block("fips_b", FIPS_B_KEY, FIPS_B_PT, FIPS_B_CT, 0, 1'b0, '0, acc1);

    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      bp  = int'($urandom_range(0, 3));
      do_block($sformatf("rnd%0d", n), key, pt, aes_encrypt(key, pt), bp, 1'b0, '0, acc1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Iterative AES-128 encryption controller that sequences the existing round-key and round-function datapath, one round per clock. It selects the round key (0..NR) from the Key_Expansion outputs through an external mux driven by rk_sel. It owns the 128-bit state register and performs AddRoundKey internally. It talks to the surrounding system through valid/ready handshakes on both plaintext input and ciphertext output.

Parameters:
NR, 10, number of AES rounds (AES-128); also the highest rk_sel value
BLOCK_W, 128, state/key block width in bits
SEL_W, 4, width of rk_sel; must satisfy 2**SEL_W > NR

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  plaintext block offered
in_ready  output  1  sequencer can accept a block
in_data  input  BLOCK_W  plaintext block
rk_sel  output  SEL_W  round-key index driven to the external round-key mux
rk_data  input  BLOCK_W  selected round key returned combinationally (round_key[rk_sel])
rnd_state  output  BLOCK_W  current state to the external round function (SubBytes/ShiftRows/MixColumns)
rnd_last  output  1  final round; round function must skip MixColumns
rnd_result  input  BLOCK_W  round-function output before AddRoundKey, combinational from rnd_state
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_data  output  BLOCK_W  ciphertext, equals the state register
busy  output  1  high in ROUND or DONE

Behaviour:
- FSM states: IDLE, ROUND, DONE. Round counter rnd_cnt is SEL_W bits wide.
- Reset (rst_n low at a clock edge):
  - state goes to IDLE; rnd_cnt=0; state register=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, rk_sel=0, rnd_last=0, out_data=0, rnd_state=0.
  - Reset mid-operation discards the block in flight. No output is produced for it.
- IDLE:
  - in_ready=1, rk_sel=0.
  - On in_valid&&in_ready: state register <= in_data ^ rk_data (initial AddRoundKey), rnd_cnt <= 1, go to ROUND.
- ROUND:
  - in_ready=0, rk_sel=rnd_cnt, rnd_state=state register, rnd_last=(rnd_cnt==NR).
  - Each cycle: state register <= rnd_result ^ rk_data.
  - If rnd_cnt==NR: go to DONE, rnd_cnt <= 0. Otherwise rnd_cnt <= rnd_cnt+1.
- DONE:
  - out_valid=1, out_data stable, rk_sel=0, rnd_last=0.
  - On out_ready: go to IDLE.
  - out_valid never drops without a handshake. out_data must not change while out_valid=1 && !out_ready.
- Latency: with the accept edge as edge 0, rounds complete on edges 1..NR. out_valid is high in the cycle after edge NR (11 cycles after acceptance for NR=10).
- Throughput: NR+2 cycles per block when out_ready is held high (accept cycle, NR round cycles, one DONE cycle).
- in_ready is 0 in ROUND and DONE. No overlap between blocks: in_valid during busy is ignored and in_data is not sampled.
- A block is accepted only in IDLE, so simultaneous out handshake and in_valid in DONE accepts nothing. The new block is accepted in the following IDLE cycle.
- rnd_cnt never exceeds NR and never wraps. Any illegal FSM encoding returns to IDLE.
- All outputs are registered or decoded from the FSM and registers only. There is no combinational path from in_valid or out_ready to any output.

Decomposition:
- Shared package aes_pkg holds:
  - constants AES_NR=10, AES_BLOCK_W=128, AES_SEL_W=4
  - FSM state typedef {IDLE, ROUND, DONE}
  - the FIPS-197 Appendix B/C.1 test vectors for benches
- No sub-module. AddRoundKey is an inline XOR. The round function and the round-key mux stay outside, in the existing datapath.

Test Plan:
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 11 cycles after accept, out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
2. Key and round sequencing: during the block in scenario 1 -> rk_sel goes 0,1,2,...,10 on consecutive cycles, rnd_last=1 only while rk_sel=10, then rk_sel=0.
3. Output backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data stays 69c4e0d8..., in_ready=0; release -> IDLE next cycle.
4. Busy input: drive in_valid=1 with a different in_data throughout scenario 1 -> no accept until IDLE, first result unchanged; second block accepted the cycle after the out handshake, period 12 cycles.
5. Reset mid-round: assert rst_n=0 at round 5 for one cycle -> next cycle in_ready=1, out_valid=0, busy=0, rk_sel=0, out_data=0; no ciphertext emitted; a fresh block then gives the correct result.
6. FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, in_data 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32.
